// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, writeback-select encodings and the
// decoded control bundle carried from ID into EX.
package cpu_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] RF_ALU = 2'd0;
  localparam logic [1:0] RF_MEM = 2'd1;
  localparam logic [1:0] RF_PC4 = 2'd2;
  localparam logic [1:0] RF_IMM = 2'd3;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read2;
    logic [1:0] rf_sel;
    logic [3:0] alu_fun;
    logic       alu_srca;
    logic [1:0] alu_srcb;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: decodes which source registers the ID
// instruction actually reads and compares them against a load in EX.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [6:0] id_opcode_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_read2_i,
  input  logic [4:0] ex_rd_addr_i,
  output logic       hz_o
);

  logic uses_rs1, uses_rs2;

  always_comb begin
    uses_rs1 = !(id_opcode_i == OP_LUI || id_opcode_i == OP_AUIPC ||
                 id_opcode_i == OP_JAL);
    uses_rs2 = (id_opcode_i == OP_REG || id_opcode_i == OP_STORE ||
                id_opcode_i == OP_BRANCH);
  end

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign hz_o = id_valid_i & ex_valid_i & ex_mem_read2_i & (ex_rd_addr_i != 5'd0) &
                ((uses_rs1 & (id_rs1_addr_i == ex_rd_addr_i)) |
                 (uses_rs2 & (id_rs2_addr_i == ex_rd_addr_i)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, downstream hold,
// redirect flush and a saturating bubble counter.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            id_valid_i,
  input  logic [6:0]      id_opcode_i,
  input  logic            id_reg_write_i,
  input  logic            id_mem_write_i,
  input  logic            id_mem_read2_i,
  input  logic [1:0]      id_rf_sel_i,
  input  logic [3:0]      id_alu_fun_i,
  input  logic            id_alu_srca_i,
  input  logic [1:0]      id_alu_srcb_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic [4:0]      id_rd_addr_i,
  input  logic            ex_hold_i,
  input  logic            flush_i,
  output logic            ex_valid_o,
  output logic            ex_reg_write_o,
  output logic            ex_mem_write_o,
  output logic            ex_mem_read2_o,
  output logic [1:0]      ex_rf_sel_o,
  output logic [3:0]      ex_alu_fun_o,
  output logic            ex_alu_srca_o,
  output logic [1:0]      ex_alu_srcb_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rs1_addr_o,
  output logic [4:0]      ex_rs2_addr_o,
  output logic [4:0]      ex_rd_addr_o,
  output logic            id_stall_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  ctrl_t            ctrl_d, ctrl_q;
  logic             valid_q;
  logic [XLEN-1:0]  pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]       rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [CNT_W-1:0] bcnt_q;
  logic             hz;

  hazard_detect u_hazard (
    .id_valid_i     (id_valid_i),
    .id_opcode_i    (id_opcode_i),
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .ex_valid_i     (valid_q),
    .ex_mem_read2_i (ctrl_q.mem_read2),
    .ex_rd_addr_i   (rd_addr_q),
    .hz_o           (hz)
  );

  // Write enables are qualified here so a captured non-instruction can never commit
  always_comb begin
    ctrl_d           = '0;
    ctrl_d.reg_write = id_reg_write_i & id_valid_i;
    ctrl_d.mem_write = id_mem_write_i & id_valid_i;
    ctrl_d.mem_read2 = id_mem_read2_i;
    ctrl_d.rf_sel    = id_rf_sel_i;
    ctrl_d.alu_fun   = id_alu_fun_i;
    ctrl_d.alu_srca  = id_alu_srca_i;
    ctrl_d.alu_srcb  = id_alu_srcb_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (!ex_hold_i) begin
      if (hz) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
      end else begin
        valid_q    <= id_valid_i;
        ctrl_q     <= ctrl_d;
        pc_q       <= id_pc_i;
        rs1_data_q <= id_rs1_data_i;
        rs2_data_q <= id_rs2_data_i;
        imm_q      <= id_imm_i;
        rs1_addr_q <= id_rs1_addr_i;
        rs2_addr_q <= id_rs2_addr_i;
        rd_addr_q  <= id_rd_addr_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      bcnt_q <= '0;
    else if (!flush_i && !ex_hold_i && hz && (bcnt_q != {CNT_W{1'b1}}))
      bcnt_q <= bcnt_q + 1'b1;
  end

  // Reset gating keeps the front end free-running while the pipe is held in reset
  assign id_stall_o = (hz | ex_hold_i) & ~flush_i & rst_n_i;

  assign ex_valid_o     = valid_q;
  assign ex_reg_write_o = ctrl_q.reg_write;
  assign ex_mem_write_o = ctrl_q.mem_write;
  assign ex_mem_read2_o = ctrl_q.mem_read2;
  assign ex_rf_sel_o    = ctrl_q.rf_sel;
  assign ex_alu_fun_o   = ctrl_q.alu_fun;
  assign ex_alu_srca_o  = ctrl_q.alu_srca;
  assign ex_alu_srcb_o  = ctrl_q.alu_srcb;
  assign ex_pc_o        = pc_q;
  assign ex_rs1_data_o  = rs1_data_q;
  assign ex_rs2_data_o  = rs2_data_q;
  assign ex_imm_o       = imm_q;
  assign ex_rs1_addr_o  = rs1_addr_q;
  assign ex_rs2_addr_o  = rs2_addr_q;
  assign ex_rd_addr_o   = rd_addr_q;
  assign bubble_cnt_o   = bcnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic checked
// against a slot-level model of the EX register.
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, id_rw, id_mw, id_mr, id_sa, ex_hold, flush;
  logic [6:0] id_op;
  logic [1:0] id_rf, id_sb;
  logic [3:0] id_fun;
  logic [XLEN-1:0] id_pc, id_r1d, id_r2d, id_imm;
  logic [4:0] id_r1a, id_r2a, id_rd;

  logic ex_valid, ex_rw, ex_mw, ex_mr, ex_sa, id_stall;
  logic [1:0] ex_rf, ex_sb;
  logic [3:0] ex_fun;
  logic [XLEN-1:0] ex_pc, ex_r1d, ex_r2d, ex_imm;
  logic [4:0] ex_r1a, ex_r2a, ex_rd;
  logic [CNT_W-1:0] bcnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .id_valid_i(id_valid), .id_opcode_i(id_op),
    .id_reg_write_i(id_rw), .id_mem_write_i(id_mw), .id_mem_read2_i(id_mr),
    .id_rf_sel_i(id_rf), .id_alu_fun_i(id_fun), .id_alu_srca_i(id_sa), .id_alu_srcb_i(id_sb),
    .id_pc_i(id_pc), .id_rs1_data_i(id_r1d), .id_rs2_data_i(id_r2d), .id_imm_i(id_imm),
    .id_rs1_addr_i(id_r1a), .id_rs2_addr_i(id_r2a), .id_rd_addr_i(id_rd),
    .ex_hold_i(ex_hold), .flush_i(flush),
    .ex_valid_o(ex_valid), .ex_reg_write_o(ex_rw), .ex_mem_write_o(ex_mw), .ex_mem_read2_o(ex_mr),
    .ex_rf_sel_o(ex_rf), .ex_alu_fun_o(ex_fun), .ex_alu_srca_o(ex_sa), .ex_alu_srcb_o(ex_sb),
    .ex_pc_o(ex_pc), .ex_rs1_data_o(ex_r1d), .ex_rs2_data_o(ex_r2d), .ex_imm_o(ex_imm),
    .ex_rs1_addr_o(ex_r1a), .ex_rs2_addr_o(ex_r2a), .ex_rd_addr_o(ex_rd),
    .id_stall_o(id_stall), .bubble_cnt_o(bcnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: contents of the EX slot as plain variables
  int m_valid, m_rw, m_mw, m_mr, m_rf, m_fun, m_sa, m_sb, m_cnt;
  logic [XLEN-1:0] m_pc, m_r1d, m_r2d, m_imm;
  int m_r1a, m_r2a, m_rd;

  function automatic void model_reset();
    m_valid = 0; m_rw = 0; m_mw = 0; m_mr = 0; m_rf = 0; m_fun = 0; m_sa = 0; m_sb = 0;
    m_cnt = 0; m_pc = '0; m_r1d = '0; m_r2d = '0; m_imm = '0; m_r1a = 0; m_r2a = 0; m_rd = 0;
  endfunction

  function automatic bit model_hz();
    bit reads1, reads2;
    reads1 = !(id_op inside {OP_LUI, OP_AUIPC, OP_JAL});
    reads2 = id_op inside {OP_REG, OP_STORE, OP_BRANCH};
    if (!(id_valid && m_valid != 0 && m_mr != 0 && m_rd != 0)) return 1'b0;
    return (reads1 && int'(id_r1a) == m_rd) || (reads2 && int'(id_r2a) == m_rd);
  endfunction

  task automatic check_all();
    chk("ex_valid", ex_valid, m_valid[0]);
    chk("ex_reg_write", ex_rw, m_rw[0]);
    chk("ex_mem_write", ex_mw, m_mw[0]);
    chk("ex_mem_read2", ex_mr, m_mr[0]);
    chk("ex_rf_sel", ex_rf, m_rf[1:0]);
    chk("ex_alu_fun", ex_fun, m_fun[3:0]);
    chk("ex_alu_srca", ex_sa, m_sa[0]);
    chk("ex_alu_srcb", ex_sb, m_sb[1:0]);
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_rs1_data", ex_r1d, m_r1d);
    chk("ex_rs2_data", ex_r2d, m_r2d);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_rs1_addr", ex_r1a, m_r1a[4:0]);
    chk("ex_rs2_addr", ex_r2a, m_r2a[4:0]);
    chk("ex_rd_addr", ex_rd, m_rd[4:0]);
    chk("bubble_cnt", bcnt, m_cnt[CNT_W-1:0]);
  endtask

  // Called at negedge with inputs set; checks the stall, clocks, updates model, checks EX.
  task automatic step();
    bit hz;
    #1;
    hz = model_hz();
    chk("id_stall", id_stall, (hz || ex_hold) && !flush);
    @(posedge clk);
    if (flush) begin
      m_valid = 0; m_rw = 0; m_mw = 0; m_mr = 0; m_rf = 0; m_fun = 0; m_sa = 0; m_sb = 0;
    end else if (!ex_hold) begin
      if (hz) begin
        m_valid = 0; m_rw = 0; m_mw = 0; m_mr = 0; m_rf = 0; m_fun = 0; m_sa = 0; m_sb = 0;
        if (m_cnt < CMAX) m_cnt++;
      end else begin
        m_valid = id_valid; m_rw = id_rw && id_valid; m_mw = id_mw && id_valid;
        m_mr = id_mr; m_rf = id_rf; m_fun = id_fun; m_sa = id_sa; m_sb = id_sb;
        m_pc = id_pc; m_r1d = id_r1d; m_r2d = id_r2d; m_imm = id_imm;
        m_r1a = id_r1a; m_r2a = id_r2a; m_rd = id_rd;
      end
    end
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] op, input int rd, input int rs1, input int rs2,
                           input int imm);
    id_valid = 1'b1; id_op = op; id_rd = 5'(rd); id_r1a = 5'(rs1); id_r2a = 5'(rs2);
    id_imm = XLEN'(imm); id_pc = id_pc + 32'd4;
    id_r1d = $urandom; id_r2d = $urandom;
    id_mr = (op == OP_LOAD); id_mw = (op == OP_STORE);
    id_rw = !(op inside {OP_STORE, OP_BRANCH});
    id_rf = (op == OP_LOAD) ? RF_MEM : RF_ALU;
    id_fun = 4'd0; id_sa = 1'b0;
    id_sb = (op == OP_REG) ? 2'b00 : 2'b01;
    ex_hold = 1'b0; flush = 1'b0;
  endtask

  logic [6:0] ops [9];

  initial begin
    ops = '{OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC, OP_IMM, OP_REG, OP_BRANCH, OP_JAL, OP_JALR};
    id_pc = '0;
    set_instr(OP_IMM, 0, 0, 0, 0);
    id_valid = 1'b0;
    ex_hold = 1'b1;
    model_reset();
    #3;
    chk("reset_stall", id_stall, 1'b0);
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ex_hold = 1'b0;

    // ADDI x5,x1,7 pass-through
    set_instr(OP_IMM, 5, 1, 0, 7);
    step();
    chk("addi_valid", ex_valid, 1'b1);
    chk("addi_rd", ex_rd, 5'd5);
    chk("addi_imm", ex_imm, 32'd7);
    chk("addi_rw", ex_rw, 1'b1);

    // LW x3 then ADD x4,x3,x2: exactly one bubble
    set_instr(OP_LOAD, 3, 1, 0, 0);
    step();
    set_instr(OP_REG, 4, 3, 2, 0);
    #1 chk("lu_stall", id_stall, 1'b1);
    step();
    chk("lu_bubble", ex_valid, 1'b0);
    chk("lu_cnt", bcnt, 4'd1);
    step();
    chk("lu_add_valid", ex_valid, 1'b1);
    chk("lu_add_rs1", ex_r1a, 5'd3);

    // No false stalls
    set_instr(OP_LOAD, 0, 1, 0, 0); step();
    set_instr(OP_REG, 1, 0, 0, 0);
    #1 chk("x0_stall", id_stall, 1'b0);
    set_instr(OP_LOAD, 3, 1, 0, 0); step();
    set_instr(OP_LUI, 3, 3, 3, 32'h1000);
    #1 chk("lui_stall", id_stall, 1'b0);
    set_instr(OP_LOAD, 3, 1, 0, 0); step();
    set_instr(OP_IMM, 6, 1, 3, 1);
    #1 chk("addi_rs2_stall", id_stall, 1'b0);
    step();

    // Hold for 3 cycles, then flush with hold
    set_instr(OP_IMM, 7, 2, 0, 9); step();
    set_instr(OP_REG, 8, 1, 2, 0);
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_rd", ex_rd, 5'd7);
      chk("hold_imm", ex_imm, 32'd9);
    end
    flush = 1'b1;
    #1 chk("flush_stall", id_stall, 1'b0);
    step();
    chk("flush_valid", ex_valid, 1'b0);
    flush = 1'b0; ex_hold = 1'b0;

    // 17 more load-use bubbles: counter saturates
    for (int i = 0; i < 17; i++) begin
      set_instr(OP_LOAD, 3, 1, 0, 0); step();
      set_instr(OP_STORE, 0, 1, 3, 0); step(); step();
    end
    chk("sat_cnt", bcnt, 4'd15);

    // Reset mid-stream between edges
    set_instr(OP_REG, 4, 1, 2, 0); id_fun = 4'd5; step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_fun", ex_fun, 4'd0);
    chk("rst_cnt", bcnt, 4'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int k;
      k = $urandom_range(0, 9);
      id_op = (k == 9) ? 7'($urandom) : ops[k];
      id_valid = ($urandom_range(0, 9) < 8);
      id_rw = 1'($urandom); id_mw = 1'($urandom);
      id_mr = (id_op == OP_LOAD) ? ($urandom_range(0, 3) != 0) : 1'($urandom);
      id_rf = 2'($urandom); id_fun = 4'($urandom); id_sa = 1'($urandom); id_sb = 2'($urandom);
      id_pc = $urandom; id_r1d = $urandom; id_r2d = $urandom; id_imm = $urandom;
      id_r1a = 5'($urandom_range(0, 3)); id_r2a = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      ex_hold = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register, directly downstream of the control unit.
- Captures the decoded control bundle, operands, immediate and register addresses each cycle and presents them to EX.
- Detects load-use hazards, stalling IF/ID and injecting a bubble.
- Honours a downstream hold and a branch/jump flush, and keeps a saturating bubble counter for performance monitoring.

Parameters:
- XLEN, 32, datapath width (PC, operands, immediate).
- CNT_W, 16, bubble-counter width.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- ID_VALID  in  1  decode slot holds a real instruction
- ID_OPCODE  in  7  ir[6:0], used for hazard source-use decode
- ID_REG_WRITE, ID_MEM_WRITE, ID_MEM_READ2  in  1 each  control from decode
- ID_RF_SEL  in  2  writeback select
- ID_ALU_FUN  in  4  ALU function
- ID_ALU_SRCA  in  1  ALU A select
- ID_ALU_SRCB  in  2  ALU B select
- ID_PC  in  XLEN  instruction PC
- ID_RS1_DATA, ID_RS2_DATA  in  XLEN each  register-file read data
- ID_IMM  in  XLEN  generated immediate
- ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR  in  5 each  register indices
- EX_HOLD  in  1  downstream not ready; freeze EX register
- FLUSH  in  1  redirect taken; kill ID and EX contents
- EX_VALID  out  1  EX slot valid
- EX_REG_WRITE, EX_MEM_WRITE, EX_MEM_READ2  out  1 each  registered control
- EX_RF_SEL  out  2  registered control
- EX_ALU_FUN  out  4  registered control
- EX_ALU_SRCA  out  1  registered control
- EX_ALU_SRCB  out  2  registered control
- EX_PC, EX_RS1_DATA, EX_RS2_DATA, EX_IMM  out  XLEN each  registered data
- EX_RS1_ADDR, EX_RS2_ADDR, EX_RD_ADDR  out  5 each  registered indices
- ID_STALL  out  1  comb; freeze PC and IF/ID register
- BUBBLE_CNT  out  CNT_W  saturating count of injected load-use bubbles

Behaviour:
- Reset (RST_N low, async):
  - All EX_* outputs and BUBBLE_CNT clear to 0 immediately; EX_VALID=0.
  - ID_STALL=0 while in reset.
  - Reset asserted mid-operation discards the in-flight EX instruction.
- Source use, decoded from ID_OPCODE:
  - uses_rs1=0 for LUI (0110111), AUIPC (0010111) and JAL (1101111); 1 otherwise.
  - uses_rs2=1 only for R-type (0110011), store (0100011) and branch (1100011).
- Load-use hazard (comb): hz = ID_VALID & EX_VALID & EX_MEM_READ2 & (EX_RD_ADDR!=0) & ((uses_rs1 & ID_RS1_ADDR==EX_RD_ADDR) | (uses_rs2 & ID_RS2_ADDR==EX_RD_ADDR)).
- ID_STALL = (hz | EX_HOLD) & ~FLUSH. Combinational, same cycle.
- Register update per rising edge, first match wins:
  1. FLUSH: EX_VALID<=0 and all control outputs <=0; data fields don't-care (hold). FLUSH overrides EX_HOLD.
  2. EX_HOLD: every EX_* register keeps its value.
  3. hz: bubble inserted; EX_VALID<=0, control<=0; BUBBLE_CNT += 1, saturating at all-ones.
  4. Otherwise: capture all ID_* fields; EX_VALID<=ID_VALID.
- ID_VALID=0: control bits still captured, but EX_VALID=0. Consumers must gate REG_WRITE and MEM_WRITE with EX_VALID. This block gates them itself: EX_REG_WRITE and EX_MEM_WRITE are stored as ID_x & ID_VALID.
- Latency: one cycle ID to EX. A load followed by a dependent instruction gets exactly one bubble.
- Hazard with rd==x0: never stalls.
- Back-to-back hazards each cost one bubble. The counter increments once per bubble cycle, not during EX_HOLD.

Decomposition:
- Shared package (cpu_pkg) holds:
  - opcode constants: OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC, OP_IMM, OP_REG, OP_BRANCH, OP_JAL, OP_JALR;
  - the ctrl_t packed struct {reg_write, mem_write, mem_read2, rf_sel, alu_fun, alu_srca, alu_srcb};
  - RF_SEL encodings.
- One sub-module, hazard_detect: purely combinational source-use decode plus hz. The pipeline register and counter stay in id_ex_stage.

Test Plan:
- Reset mid-stream: drive a valid ADD, pulse RST_N low between edges -> EX_VALID=0, EX_ALU_FUN=0 and BUBBLE_CNT=0 immediately, without waiting for a clock edge.
- Pass-through: ADDI x5,x1,7 (ALU_FUN=0000, ALU_SRCB=01, IMM=7, RD=5) -> one cycle later EX_VALID=1, EX_RD_ADDR=5, EX_IMM=7, EX_REG_WRITE=1.
- Load-use: LW x3 in EX, ADD x4,x3,x2 in ID -> ID_STALL=1 for one cycle, then EX_VALID=0 bubble and BUBBLE_CNT=1; next cycle the ADD reaches EX with EX_RS1_ADDR=3.
- No false stall:
  - LW x0 followed by use of x0 -> ID_STALL=0.
  - LW x3 followed by LUI x3 -> ID_STALL=0.
  - LW x3 followed by ADDI using rs2 field=3 -> ID_STALL=0.
- Hold vs flush: EX_HOLD=1 for 3 cycles -> EX_* outputs stable and ID_STALL=1. Then FLUSH=1 together with EX_HOLD=1 -> EX_VALID=0 next edge and ID_STALL=0.
- Counter saturation: CNT_W=4, force 17 load-use bubbles -> BUBBLE_CNT stops at 15.
